// File: rtl/psram_resp_pkg.sv
// Shared definitions for the OPI PSRAM responder: FSM state encoding and OPI opcodes.
package psram_define;

  typedef enum logic [2:0] {
    PSRAM_RESP_IDLE,
    PSRAM_RESP_CMD0,
    PSRAM_RESP_CMD1,
    PSRAM_RESP_ADDR,
    PSRAM_RESP_WDATA,
    PSRAM_RESP_LAT,
    PSRAM_RESP_RDATA,
    PSRAM_RESP_ERR
  } psram_resp_state_e;

  localparam logic [7:0] PSRAM_OPI_WR_REG = 8'hC0;
  localparam logic [7:0] PSRAM_OPI_RD_REG = 8'h40;
  localparam logic [1:0] PSRAM_MODE_OPI   = 2'd2;

endpackage

// File: rtl/psram_resp_sync.sv
// Two-flop synchronizer for SCK, CE and DQ, with SCK edge and CE falling-edge detection.
module psram_resp_sync (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sck_i,
  input  logic       ce_i,
  input  logic [7:0] io_i,
  output logic       sck_edge_o,
  output logic       ce_s_o,
  output logic       ce_fall_o,
  output logic [7:0] io_s_o
);

  logic [2:0] sck_q;
  logic [2:0] ce_q;
  logic [7:0] io_q1;
  logic [7:0] io_q2;

  // CE stages reset high so a frame needs a fresh CE low after reset release
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_q <= 3'b000;
      ce_q  <= 3'b111;
      io_q1 <= 8'h00;
      io_q2 <= 8'h00;
    end else begin
      sck_q <= {sck_q[1:0], sck_i};
      ce_q  <= {ce_q[1:0], ce_i};
      io_q1 <= io_i;
      io_q2 <= io_q1;
    end
  end

  assign sck_edge_o = sck_q[1] ^ sck_q[2];
  assign ce_s_o     = ce_q[1];
  assign ce_fall_o  = ce_q[2] & ~ce_q[1];
  assign io_s_o     = io_q2;

endmodule

// File: rtl/psram_resp.sv
// OPI PSRAM device-side responder for mode-register write/read frames.
// Optional build macro PSRAM_RESP_ADDR_INC_EN enables address auto-increment bursts.
module psram_resp
  import psram_define::*;
#(
  parameter int         RD_LAT     = 5,
  parameter logic [7:0] WR_REG_CMD = PSRAM_OPI_WR_REG,
  parameter logic [7:0] RD_REG_CMD = PSRAM_OPI_RD_REG
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_in_i,
  output logic [7:0] psram_io_out_o,
  output logic [7:0] psram_io_en_o,
  output logic       psram_dqs_out_o,
  output logic       psram_dqs_en_o,
  output logic       mr_wr_o,
  output logic [7:0] mr_addr_o,
  output logic [7:0] mr_wdata_o,
  input  logic [7:0] mr_rdata_i
);

  localparam logic [7:0] LAT_LAST = 8'(2 * RD_LAT - 1);

  logic              sck_edge;
  logic              ce_s;
  logic              ce_fall;
  logic [7:0]        io_s;
  psram_resp_state_e state;
  logic [7:0]        opcode;
  logic [7:0]        cnt;
`ifdef PSRAM_RESP_ADDR_INC_EN
  logic              wr_inc_pend;
  logic              rd_reload_pend;
`endif

  psram_resp_sync u_sync (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .sck_i      (psram_sck_i),
    .ce_i       (psram_ce_i),
    .io_i       (psram_io_in_i),
    .sck_edge_o (sck_edge),
    .ce_s_o     (ce_s),
    .ce_fall_o  (ce_fall),
    .io_s_o     (io_s)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= PSRAM_RESP_IDLE;
      opcode          <= 8'h00;
      cnt             <= 8'h00;
      psram_io_out_o  <= 8'h00;
      psram_io_en_o   <= 8'h00;
      psram_dqs_out_o <= 1'b0;
      psram_dqs_en_o  <= 1'b0;
      mr_wr_o         <= 1'b0;
      mr_addr_o       <= 8'h00;
      mr_wdata_o      <= 8'h00;
`ifdef PSRAM_RESP_ADDR_INC_EN
      wr_inc_pend     <= 1'b0;
      rd_reload_pend  <= 1'b0;
`endif
    end else begin
      mr_wr_o <= 1'b0;
`ifdef PSRAM_RESP_ADDR_INC_EN
      // Address moves one clk after a write so the pulse sees the old address;
      // read data reloads one clk after the address moves so mr_rdata_i has settled.
      wr_inc_pend    <= 1'b0;
      rd_reload_pend <= 1'b0;
      if (wr_inc_pend) mr_addr_o <= mr_addr_o + 8'd1;
      if (rd_reload_pend) psram_io_out_o <= mr_rdata_i;
`endif
      if (ce_s) begin
        state           <= PSRAM_RESP_IDLE;
        psram_io_en_o   <= 8'h00;
        psram_dqs_en_o  <= 1'b0;
        psram_dqs_out_o <= 1'b0;
        cnt             <= 8'h00;
      end else begin
        case (state)
          PSRAM_RESP_IDLE: begin
            if (ce_fall) state <= PSRAM_RESP_CMD0;
          end
          PSRAM_RESP_CMD0: begin
            if (sck_edge) begin
              opcode <= io_s;
              state  <= PSRAM_RESP_CMD1;
            end
          end
          PSRAM_RESP_CMD1: begin
            if (sck_edge) begin
              if (io_s == opcode && (io_s == WR_REG_CMD || io_s == RD_REG_CMD)) begin
                state <= PSRAM_RESP_ADDR;
                cnt   <= 8'h00;
              end else begin
                state <= PSRAM_RESP_ERR;
              end
            end
          end
          PSRAM_RESP_ADDR: begin
            // Only the low address byte matters for mode registers
            if (sck_edge) begin
              mr_addr_o <= io_s;
              cnt       <= cnt + 8'd1;
              if (cnt == 8'd3) begin
                cnt <= 8'h00;
                if (opcode == WR_REG_CMD) begin
                  state <= PSRAM_RESP_WDATA;
                end else begin
                  state           <= PSRAM_RESP_LAT;
                  psram_dqs_en_o  <= 1'b1;
                  psram_dqs_out_o <= 1'b0;
                end
              end
            end
          end
          PSRAM_RESP_WDATA: begin
            if (sck_edge) begin
`ifdef PSRAM_RESP_ADDR_INC_EN
              mr_wdata_o  <= io_s;
              mr_wr_o     <= 1'b1;
              wr_inc_pend <= 1'b1;
`else
              if (cnt == 8'h00) begin
                mr_wdata_o <= io_s;
                mr_wr_o    <= 1'b1;
                cnt        <= 8'h01;
              end
`endif
            end
          end
          PSRAM_RESP_LAT: begin
            if (sck_edge) begin
              cnt <= cnt + 8'd1;
              if (cnt == LAT_LAST) begin
                cnt            <= 8'h00;
                psram_io_out_o <= mr_rdata_i;
                psram_io_en_o  <= 8'hFF;
                state          <= PSRAM_RESP_RDATA;
              end
            end
          end
          PSRAM_RESP_RDATA: begin
            if (sck_edge) begin
              psram_dqs_out_o <= ~psram_dqs_out_o;
`ifdef PSRAM_RESP_ADDR_INC_EN
              if (psram_dqs_out_o) begin
                mr_addr_o      <= mr_addr_o + 8'd1;
                rd_reload_pend <= 1'b1;
              end
`endif
            end
          end
          PSRAM_RESP_ERR: begin
            state <= PSRAM_RESP_ERR;
          end
          default: state <= PSRAM_RESP_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psram_resp.sv
// Self-checking bench for psram_resp: randomized register frames against a behavioural model.
// Honours PSRAM_RESP_ADDR_INC_EN in its expectations.
module tb_psram_resp;

  logic       clk_i;
  logic       rst_n_i;
  logic       sck;
  logic       ce;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [7:0] io_en;
  logic       dqs_out;
  logic       dqs_en;
  logic       mr_wr;
  logic [7:0] mr_addr;
  logic [7:0] mr_wdata;
  logic [7:0] mr_rdata;

  logic [7:0]  regs [256];
  logic [7:0]  wdat [8];
  logic [15:0] wr_log [$];
  int          checks = 0;
  int          passed = 0;
  int          failed = 0;

  localparam logic [7:0] WR = 8'hC0;
  localparam logic [7:0] RD = 8'h40;

  psram_resp dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .psram_sck_i     (sck),
    .psram_ce_i      (ce),
    .psram_io_in_i   (io_in),
    .psram_io_out_o  (io_out),
    .psram_io_en_o   (io_en),
    .psram_dqs_out_o (dqs_out),
    .psram_dqs_en_o  (dqs_en),
    .mr_wr_o         (mr_wr),
    .mr_addr_o       (mr_addr),
    .mr_wdata_o      (mr_wdata),
    .mr_rdata_i      (mr_rdata)
  );

  assign mr_rdata = regs[mr_addr];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Register-write monitor: every pulse is logged as {address, data}
  always @(negedge clk_i) begin
    if (rst_n_i && mr_wr) wr_log.push_back({mr_addr, mr_wdata});
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running required done");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // One DDR SCK edge carrying byte b; DQ is set a clk ahead of the edge
  task automatic applyStimulus(input logic [7:0] b);
    io_in = b;
    @(negedge clk_i);
    sck = ~sck;
    @(negedge clk_i);
  endtask

  task automatic startFrame();
    ce = 1'b0;
    waitClk(4);
  endtask

  task automatic endFrame();
    waitClk(4);
    ce = 1'b1;
    waitClk(4);
  endtask

  task automatic sendHeader(input logic [7:0] op, input logic [7:0] a);
    applyStimulus(op);
    applyStimulus(op);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(a);
  endtask

  function automatic int expWrites(input int n);
`ifdef PSRAM_RESP_ADDR_INC_EN
    return n;
`else
    return 1;
`endif
  endfunction

  function automatic logic [7:0] expRead(input logic [7:0] a, input int k);
    logic [7:0] idx;
`ifdef PSRAM_RESP_ADDR_INC_EN
    idx = a + 8'(k / 2);
`else
    idx = a;
`endif
    return regs[idx];
  endfunction

  task automatic writeFrame(input logic [7:0] a, input int n);
    int exp_n;
    logic [7:0] ea;
    wr_log.delete();
    startFrame();
    sendHeader(WR, a);
    for (int i = 0; i < n; i++) applyStimulus(wdat[i]);
    waitClk(4);
    checkOutput("wr_io_en", {24'h0, io_en}, 32'h0);
    endFrame();
    exp_n = expWrites(n);
    checkOutput("wr_count", wr_log.size(), exp_n);
    for (int i = 0; i < exp_n && i < wr_log.size(); i++) begin
      ea = a + 8'(i);
      checkOutput("wr_addr", {24'h0, wr_log[i][15:8]}, {24'h0, ea});
      checkOutput("wr_data", {24'h0, wr_log[i][7:0]}, {24'h0, wdat[i]});
    end
  endtask

  task automatic readToData(input logic [7:0] a);
    startFrame();
    sendHeader(RD, a);
    waitClk(3);
    checkOutput("lat_dqs_en", {31'h0, dqs_en}, 32'h1);
    checkOutput("lat_io_en", {24'h0, io_en}, 32'h0);
    repeat (9) applyStimulus(8'($urandom));
    waitClk(3);
    checkOutput("lat9_io_en", {24'h0, io_en}, 32'h0);
    checkOutput("lat9_dqs_out", {31'h0, dqs_out}, 32'h0);
    applyStimulus(8'($urandom));
    waitClk(3);
    checkOutput("rd_io_en", {24'h0, io_en}, 32'hFF);
    checkOutput("rd_first", {24'h0, io_out}, {24'h0, regs[a]});
    checkOutput("rd_dqs_start", {31'h0, dqs_out}, 32'h0);
  endtask

  task automatic readFrame(input logic [7:0] a, input int n);
    readToData(a);
    for (int k = 1; k <= n; k++) begin
      applyStimulus(8'($urandom));
      waitClk(3);
      checkOutput("rd_dqs", {31'h0, dqs_out}, 32'(k % 2));
      checkOutput("rd_data", {24'h0, io_out}, {24'h0, expRead(a, k)});
    end
    endFrame();
    checkOutput("rd_end_io_en", {24'h0, io_en}, 32'h0);
    checkOutput("rd_end_dqs_en", {31'h0, dqs_en}, 32'h0);
    checkOutput("rd_end_dqs_out", {31'h0, dqs_out}, 32'h0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    sck     = 1'b0;
    ce      = 1'b1;
    io_in   = 8'h00;
    for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
    regs[0] = 8'h8D;
    waitClk(3);
    checkOutput("rst_io_out", {24'h0, io_out}, 32'h0);
    checkOutput("rst_io_en", {24'h0, io_en}, 32'h0);
    checkOutput("rst_dqs", {30'h0, dqs_en, dqs_out}, 32'h0);
    checkOutput("rst_mr", {7'h0, mr_wr, mr_addr, mr_wdata}, 32'h0);
    rst_n_i = 1'b1;
    waitClk(3);

    $display("[TB] directed write 04=5A");
    wdat[0] = 8'h5A;
    writeFrame(8'h04, 1);

    $display("[TB] directed burst write at FE");
    wdat[0] = 8'h11;
    wdat[1] = 8'h22;
    wdat[2] = 8'h33;
    writeFrame(8'hFE, 3);

    $display("[TB] directed read at 00, latency edges");
    readFrame(8'h00, 5);

    $display("[TB] random writes and reads");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) wdat[i] = 8'($urandom);
      writeFrame(8'($urandom), int'($urandom_range(1, 5)));
      readFrame(8'($urandom), int'($urandom_range(2, 7)));
    end

    $display("[TB] opcode mismatch");
    wr_log.delete();
    startFrame();
    applyStimulus(WR);
    applyStimulus(RD);
    repeat (6) applyStimulus(8'($urandom));
    waitClk(3);
    checkOutput("err_io_en", {24'h0, io_en}, 32'h0);
    checkOutput("err_dqs", {30'h0, dqs_en, dqs_out}, 32'h0);
    endFrame();
    checkOutput("err_no_write", wr_log.size(), 0);
    wdat[0] = 8'h6C;
    writeFrame(8'h21, 1);

    $display("[TB] CE abort inside address phase");
    wr_log.delete();
    startFrame();
    applyStimulus(WR);
    applyStimulus(WR);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    waitClk(3);
    ce = 1'b1;
    waitClk(3);
    checkOutput("abort_addr_en", {23'h0, io_en, dqs_en}, 32'h0);
    waitClk(4);
    checkOutput("abort_addr_no_write", wr_log.size(), 0);

    $display("[TB] CE abort during latency");
    startFrame();
    sendHeader(RD, 8'h10);
    repeat (4) applyStimulus(8'h00);
    waitClk(3);
    ce = 1'b1;
    waitClk(2);
    checkOutput("abort_lat_hold", {31'h0, dqs_en}, 32'h1);
    waitClk(1);
    checkOutput("abort_lat_dqs_en", {31'h0, dqs_en}, 32'h0);
    checkOutput("abort_lat_io_en", {24'h0, io_en}, 32'h0);
    waitClk(4);

    $display("[TB] CE rise coincident with SCK edge");
    wr_log.delete();
    startFrame();
    sendHeader(WR, 8'h30);
    applyStimulus(8'hA1);
    io_in = 8'hB2;
    waitClk(1);
    ce  = 1'b1;
    sck = ~sck;
    waitClk(6);
    checkOutput("ce_win_count", wr_log.size(), 1);
    if (wr_log.size() > 0)
      checkOutput("ce_win_entry", {16'h0, wr_log[0]}, 32'h30A1);

    $display("[TB] reset during read data");
    readToData(8'h55);
    applyStimulus(8'h00);
    waitClk(3);
    checkOutput("pre_rst_dqs", {31'h0, dqs_out}, 32'h1);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("rst_mid_io_en", {24'h0, io_en}, 32'h0);
    checkOutput("rst_mid_dqs", {30'h0, dqs_en, dqs_out}, 32'h0);
    ce = 1'b1;
    waitClk(2);
    rst_n_i = 1'b1;
    waitClk(3);
    wdat[0] = 8'h9E;
    writeFrame(8'h07, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/psram_resp.md
Name: psram_resp

Overview:
- Synthesizable OPI PSRAM device-side responder: the target that answers the OPI controller's mode-register write/read frames.
- Oversamples psram_sck_i with clk_i (clk_i/SCK >= 4). Decodes DDR command/address bytes and drives read data and DQS back.
- Used as the bench/FPGA stand-in for the PSRAM die and as the loopback target for controller bring-up.

Parameters:
- RD_LAT, 5, read latency in SCK cycles between the last address byte and the first read data byte (2*RD_LAT edges).
- WR_REG_CMD, 8'hC0, OPI mode-register-write opcode.
- RD_REG_CMD, 8'h40, OPI mode-register-read opcode.

Ports:
- clk_i  in  1  system clock; one clock domain.
- rst_n_i  in  1  reset, asynchronous, active-low.
- psram_sck_i  in  1  SCK from the controller.
- psram_ce_i  in  1  chip enable, active-low.
- psram_io_in_i  in  8  DQ from the controller.
- psram_io_out_o  out  8  DQ to the controller.
- psram_io_en_o  out  8  DQ output enable, 1 = drive.
- psram_dqs_out_o  out  1  read strobe.
- psram_dqs_en_o  out  1  DQS output enable.
- mr_wr_o  out  1  one-clk pulse: mode-register write.
- mr_addr_o  out  8  mode-register address.
- mr_wdata_o  out  8  mode-register write data.
- mr_rdata_i  in  8  mode-register read data; combinational on mr_addr_o.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Input sampling: psram_sck_i, psram_ce_i and psram_io_in_i each pass through a 2-flop synchronizer, aligned stage for stage.
- Edge detection: edge = sck_s ^ sck_s_d, where sck_s_d is the synchronized SCK delayed by one more flop. Both SCK edges are active (DDR).
- An edge with ce_s low captures one byte, io_s. The capture latency is 3 clk from pin to decision.
- CE abort: ce_s high in any state returns the FSM to IDLE on the next clk. On that same transition io_en, dqs_en and dqs_out go to 0, and the byte counter clears. There is no mr_wr_o pulse for a partial frame.
- FSM states: IDLE, CMD0, CMD1, ADDR, WDATA, LAT, RDATA, ERR.
- IDLE -> CMD0 on ce_s falling.
- CMD0: first edge latches the opcode; go to CMD1.
- CMD1: next byte must equal the latched opcode and be WR_REG_CMD or RD_REG_CMD, otherwise go to ERR; if valid, go to ADDR.
- ADDR: 4 bytes, MSB first, shifted into a 32-bit register. mr_addr_o = addr[7:0]; upper bits are ignored. After the 4th byte: write -> WDATA, read -> LAT.
- WDATA: each edge captures a byte. The first byte drives mr_wdata_o plus a 1-clk mr_wr_o pulse on the capture clk; later bytes are handled per the optional feature. The state stays WDATA until CE high.
- LAT: dqs_en = 1 and dqs_out = 0 from entry. Count 2*RD_LAT edges with an 8-bit counter, then latch mr_rdata_i and go to RDATA.
- RDATA: io_en = 8'hFF and io_out = the latched byte. dqs_out toggles on every detected edge; the first data edge drives it 1. Data repeats until CE high.
- ERR: all outputs idle; ignore edges until CE high.
- Simultaneous CE rise and SCK edge: CE wins, and the byte is discarded.
- Reset mid-frame: asynchronous clear to IDLE; the next frame requires a CE low after reset release.

Optional Feature:
- Macro: PSRAM_RESP_ADDR_INC_EN.
- Defined: in WDATA, every captured byte issues mr_wr_o, and mr_addr_o increments by 1 after each write, wrapping 8'hFF -> 8'h00. In RDATA, the address also increments after each data byte pair (every 2 edges), and mr_rdata_i is re-latched each pair.
- Undefined: only the first write byte is committed and later ones are ignored. The read byte is fixed for the whole burst.

Decomposition:
- Shared package psram_define:
  - state enum PSRAM_RESP_{IDLE,CMD0,CMD1,ADDR,WDATA,LAT,RDATA,ERR} (3 bits);
  - opcode constants PSRAM_OPI_WR_REG / PSRAM_OPI_RD_REG;
  - PSRAM_MODE_OPI.
- Sub-module psram_resp_sync: 2-flop synchronizer for sck/ce/io plus the edge and CE-level outputs. Reuse the existing dffr/dffrh cells.

Test Plan:
- Write: CE low; bytes C0,C0,00,00,00,04,5A at clk/SCK=4 -> one mr_wr_o pulse, mr_addr_o=04, mr_wdata_o=5A; no DQ drive.
- Read, RD_LAT=5, mr_rdata_i=8'h8D: bytes 40,40,00,00,00,00 -> dqs_en=1 after the last address byte; exactly 10 edges later io_en=FF, io_out=8D, dqs_out toggles 1,0,1,...
- Opcode mismatch C0,40 -> ERR; no mr_wr_o; outputs stay 0 until CE high; the next valid frame works.
- CE raised after 3 address bytes -> within 1 clk of ce_s high: IDLE, all enables 0, no pulse.
- Reset asserted during RDATA -> io_en, dqs_en, dqs_out 0 immediately.
- With PSRAM_RESP_ADDR_INC_EN, write C0,C0,00,00,00,FE,11,22,33 -> writes FE=11, FF=22, 00=33. Without the macro -> only FE=11.
